// File: rtl/timer_pkg.sv
// Shared constants for the interval timer: register word indices and CTRL bits.
// Firmware headers carry the same values.
package timer_pkg;

    localparam logic [2:0] TIMER_CTRL     = 3'd0;
    localparam logic [2:0] TIMER_PRESCALE = 3'd1;
    localparam logic [2:0] TIMER_COUNT    = 3'd2;
    localparam logic [2:0] TIMER_COMPARE  = 3'd3;
    localparam logic [2:0] TIMER_STATUS   = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every
// prescale+1 cycles. The counter holds while disabled.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] r_pcnt;
    logic                      w_wrap;

    assign w_wrap = (r_pcnt == prescale);
    assign tick   = en & ~rst & w_wrap;

    // Advance the cycle counter, restarting on wrap or on a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (clear) begin
            r_pcnt <= '0;
        end else if (en) begin
            if (w_wrap) r_pcnt <= '0;
            else        r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer.sv
// Memory-mapped interval timer with periodic and one-shot modes and a
// level interrupt (PEND & IE). Read data is combinational on reg_addr.
module timer
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  reg_we,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [31:0] reg_q,
    output logic        irq
);

    logic [2:0]                r_ctrl;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [31:0]               r_count;
    logic [31:0]               r_compare;
    logic                      r_pend;

    logic [31:0] w_mask;
    logic        w_wr_any;
    logic        w_ctrl_wr;
    logic        w_pre_wr;
    logic        w_count_wr;
    logic        w_cmp_wr;
    logic        w_w1c;
    logic [2:0]  w_ctrl_new;
    logic        w_pcnt_clear;
    logic        w_tick;
    logic        w_match;

    assign w_mask     = byte_mask(reg_we);
    assign w_wr_any   = |reg_we;
    assign w_ctrl_wr  = w_wr_any && (reg_addr == TIMER_CTRL);
    assign w_pre_wr   = w_wr_any && (reg_addr == TIMER_PRESCALE);
    assign w_count_wr = w_wr_any && (reg_addr == TIMER_COUNT);
    assign w_cmp_wr   = w_wr_any && (reg_addr == TIMER_COMPARE);
    assign w_w1c      = reg_we[0] && (reg_addr == TIMER_STATUS) && reg_data[0];

    // Only byte lane 0 carries the implemented CTRL bits.
    assign w_ctrl_new   = reg_we[0] ? reg_data[2:0] : r_ctrl;
    // Restart the prescaler on a fresh enable or any prescale change.
    assign w_pcnt_clear = w_pre_wr ||
                          (w_ctrl_wr && !r_ctrl[CTRL_EN] && w_ctrl_new[CTRL_EN]);

    assign w_match = w_tick && (r_count == r_compare);
    assign irq     = r_pend & r_ctrl[CTRL_IE];

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (r_ctrl[CTRL_EN]),
        .clear    (w_pcnt_clear),
        .prescale (r_prescale),
        .tick     (w_tick)
    );

    // CTRL: CPU write wins; otherwise a one-shot match drops EN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= '0;
        end else if (w_ctrl_wr) begin
            r_ctrl <= w_ctrl_new;
        end else if (w_match && !r_ctrl[CTRL_PERIODIC]) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // PRESCALE and COMPARE: plain byte-lane writable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_compare  <= COMPARE_RST;
        end else begin
            if (w_pre_wr)
                r_prescale <= (r_prescale & ~w_mask[PRESCALE_WIDTH-1:0]) |
                              (reg_data[PRESCALE_WIDTH-1:0] & w_mask[PRESCALE_WIDTH-1:0]);
            if (w_cmp_wr)
                r_compare <= (r_compare & ~w_mask) | (reg_data & w_mask);
        end
    end

    // COUNT: CPU write overrides the tick update; match restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_count_wr) begin
            r_count <= (r_count & ~w_mask) | (reg_data & w_mask);
        end else if (w_tick) begin
            r_count <= w_match ? 32'd0 : r_count + 32'd1;
        end
    end

    // PEND: set on match, which beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (w_match) begin
            r_pend <= 1'b1;
        end else if (w_w1c) begin
            r_pend <= 1'b0;
        end
    end

    // Combinational read mux; unused indices read zero.
    always_comb begin
        reg_q = 32'd0;
        case (reg_addr)
            TIMER_CTRL:     reg_q = {29'd0, r_ctrl};
            TIMER_PRESCALE: reg_q = 32'(r_prescale);
            TIMER_COUNT:    reg_q = r_count;
            TIMER_COMPARE:  reg_q = r_compare;
            TIMER_STATUS:   reg_q = {31'd0, r_pend};
            default:        reg_q = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer.sv
// Bench for the interval timer: register reset table, periodic, one-shot,
// wrap, simultaneous-event, byte-lane and mid-period reset sequences.
module tb_timer;

    logic        clk;
    logic        rst;
    logic [3:0]  reg_we;
    logic [2:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] reg_q;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } vec_t;
    vec_t rst_tbl[8];

    timer #(.PRESCALE_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .reg_q    (reg_q),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_pop(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_empty: got %h with no expectation", act);
            return;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (act !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    endtask

    // Read a register: expectation queued, address driven, result compared.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        sb_q.push_back('{name, exp});
        reg_addr = a;
        #1;
        compare_pop(reg_q);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        sb_q.push_back('{name, {31'd0, exp}});
        compare_pop({31'd0, irq});
    endtask

    // Write spanning one clock edge; returns 1ns after that edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] we);
        reg_addr = a;
        reg_data = d;
        reg_we   = we;
        @(posedge clk);
        #1;
        reg_we = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_table(input string tag);
        for (int i = 0; i < 8; i++)
            rd(rst_tbl[i].addr, rst_tbl[i].exp, $sformatf("%s_idx%0d", tag, i));
        chk_irq(1'b0, {tag, "_irq"});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rst_tbl[i].addr = 3'(i);
            rst_tbl[i].exp  = (i == 3) ? 32'hFFFF_FFFF : 32'd0;
        end

        rst = 1'b1; reg_we = 4'd0; reg_addr = 3'd0; reg_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_table("reset");

        // Periodic: PRESCALE=0, COMPARE=3, CTRL=EN|PERIODIC|IE.
        wr(3'd3, 32'd3, 4'hF);
        wr(3'd0, 32'd7, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            rd(3'd2, 32'(k % 4), $sformatf("per_count_k%0d", k));
            chk_irq(k >= 4, $sformatf("per_irq_k%0d", k));
        end
        wr(3'd4, 32'd1, 4'h1);
        chk_irq(1'b0, "per_w1c_irq");
        rd(3'd2, 32'd1, "per_after_w1c_count");
        repeat (2) @(posedge clk);
        #1;
        rd(3'd2, 32'd3, "per_match_cycle_count");
        wr(3'd4, 32'd1, 4'h1);
        rd(3'd4, 32'd1, "w1c_in_match_pend");
        rd(3'd2, 32'd0, "w1c_in_match_count");
        chk_irq(1'b1, "w1c_in_match_irq");
        wr(3'd4, 32'd1, 4'h1);
        rd(3'd4, 32'd0, "w1c_plain_pend");
        repeat (2) @(posedge clk);
        #1;
        rd(3'd2, 32'd3, "cntwr_match_cycle_count");
        rd(3'd4, 32'd0, "cntwr_pre_pend");
        wr(3'd2, 32'h10, 4'hF);
        rd(3'd2, 32'h10, "cntwr_in_match_count");
        rd(3'd4, 32'd1, "cntwr_in_match_pend");
        rd(3'd0, 32'd7, "cntwr_in_match_ctrl");

        // One-shot: PRESCALE=9, COMPARE=1, CTRL=EN|IE.
        do_reset();
        wr(3'd1, 32'd9, 4'hF);
        wr(3'd3, 32'd1, 4'hF);
        wr(3'd0, 32'd5, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            rd(3'd2, (k >= 10 && k < 20) ? 32'd1 : 32'd0, $sformatf("os_count_k%0d", k));
            chk_irq(k == 20, $sformatf("os_irq_k%0d", k));
        end
        rd(3'd0, 32'd4, "os_ctrl_en_cleared");
        repeat (30) @(posedge clk);
        #1;
        rd(3'd2, 32'd0, "os_count_holds");
        rd(3'd4, 32'd1, "os_pend_holds");

        // Wrap: COUNT=0xFFFFFFFE, COMPARE=5, PRESCALE=0, EN only.
        do_reset();
        wr(3'd2, 32'hFFFF_FFFE, 4'hF);
        wr(3'd3, 32'd5, 4'hF);
        wr(3'd0, 32'd1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            rd(3'd2, (k == 8) ? 32'd0 : 32'hFFFF_FFFE + 32'(k), $sformatf("wrap_count_k%0d", k));
            rd(3'd4, {31'd0, k == 8}, $sformatf("wrap_pend_k%0d", k));
            chk_irq(1'b0, $sformatf("wrap_irq_k%0d", k));
        end

        // Byte lanes and unmapped index.
        do_reset();
        wr(3'd3, 32'd0, 4'hF);
        wr(3'd3, 32'hAABB_CCDD, 4'b0010);
        rd(3'd3, 32'h0000_CC00, "bytelane_compare");
        wr(3'd5, 32'h1234_5678, 4'hF);
        rd(3'd5, 32'd0, "idx5_ignored");

        // Reset asserted mid-period.
        wr(3'd1, 32'd3, 4'hF);
        wr(3'd3, 32'd100, 4'hF);
        wr(3'd0, 32'd7, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        rd(3'd2, 32'd2, "midrst_pre_count");
        do_reset();
        check_reset_table("midrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Memory-mapped interval timer on the picorv32 bus, decoded by the top-level chip select at 0x70000-0x70010. Produces a level interrupt that the top level ORs into `cpu_irq` bit 5, beside the UART interrupts. Used for periodic OS ticks and one-shot delays. Read data is combinational and the top level asserts ready in the same cycle as chip select, as it does for the encoder registers.

## Interface
- `PRESCALE_WIDTH`, default 16: width of the prescaler register and its counter.
- `clk`  in  1  system clock, 25 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `reg_we`  in  4  byte write strobes; already gated by chip select in the top level; 0 means no write.
- `reg_addr`  in  3  word index, taken from `cpu_mem_addr[4:2]`.
- `reg_data`  in  32  write data.
- `reg_q`  out  32  read data; combinational on `reg_addr`.
- `irq`  out  1  level interrupt, equal to `STATUS.PEND & CTRL.IE`.

## Operation
- Register map (word index):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0.
  - 1 PRESCALE.
  - 2 COUNT, 32 bits.
  - 3 COMPARE, 32 bits.
  - 4 STATUS: bit0 PEND, write-1-to-clear.
  - Indices 5-7 read 0; writes to them are ignored.
- Every byte lane is honoured on CTRL, PRESCALE, COUNT and COMPARE. STATUS acts only on `reg_we[0]`.
- Prescaler:
  - While EN=1, `pcnt` increments each cycle.
  - When `pcnt == PRESCALE`, a one-cycle `tick` is generated and `pcnt` is set to 0.
  - This gives one tick every PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - While EN=0, `pcnt` holds.
- On a tick:
  - If COUNT == COMPARE (match): PEND is set to 1 and COUNT is set to 0.
    - PERIODIC=1: EN stays 1.
    - PERIODIC=0: EN is cleared (one-shot).
  - Otherwise COUNT increments, wrapping from 0xFFFFFFFF to 0.
- Period in periodic mode is (COMPARE+1)*(PRESCALE+1) cycles.
- Writes:
  - A CTRL write that changes EN from 0 to 1 clears `pcnt`.
  - Any PRESCALE write clears `pcnt`.
  - A COUNT write does not affect `pcnt`.
- Simultaneous events:
  - CPU write to COUNT in a tick cycle: the write wins and the tick's count update is discarded. The match check still uses the old COUNT. PEND may set, and a one-shot EN clear still applies unless the same cycle writes CTRL.
  - CPU write to CTRL in a match cycle: the CPU value wins for all CTRL bits.
  - STATUS W1C in a match cycle: PEND stays 1 (set wins).
  - Changing COMPARE to a value below the current COUNT: no match until COUNT wraps.

## Timing
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=0xFFFFFFFF, PEND=0, `pcnt`=0, `irq`=0. `reg_q` shows these values.
- Reset asserted mid-count returns everything to the reset values on the next edge. No tick is generated in the reset cycle.
- All register writes take effect at the clock edge ending the write cycle, and are visible on `reg_q` in the following cycle.
- Tick cycle timing:
  - EN set at edge E with PRESCALE=P: the first tick cycle is the cycle after edge E+P; its COUNT update lands at edge E+P+1.
  - PEND and `irq` rise at the edge that ends the matching tick cycle; there is no added latency.
  - `irq` falls in the cycle after a STATUS W1C write or an IE clear.

## Structure
- `timer_pkg`, shared package, holds:
  - Register index constants: TIMER_CTRL=0, TIMER_PRESCALE=1, TIMER_COUNT=2, TIMER_COMPARE=3, TIMER_STATUS=4.
  - CTRL bit positions: EN=0, PERIODIC=1, IE=2.
  - Firmware headers mirror these values.
- Sub-module `timer_prescaler`:
  - Holds `pcnt` and the PRESCALE compare.
  - Inputs: `clk`, `rst`, `en`, `clear`, `prescale`. Output: `tick`.
- Top level, outside this block:
  - Adds `timer_cs` at `cpu_mem_addr[19:16]==4'h7`.
  - Adds `timer_cs` to the ready OR.
  - Adds the read mux entry.
  - Drives `irq` into `cpu_irq[5]`.

## Test plan
- Reset, then read indices 0-7 -> 0, 0, 0, 0xFFFFFFFF, 0, 0, 0, 0; `irq`=0.
- PRESCALE=0, COMPARE=3, CTRL=0b111 -> PEND and `irq` rise 4 cycles after EN.
  - COUNT returns to 0 and repeats every 4 cycles.
  - W1C on STATUS drops `irq` the next cycle.
- PRESCALE=9, COMPARE=1, CTRL=0b101 (one-shot) -> PEND after 20 cycles.
  - EN reads 0 afterwards, COUNT holds 0, and no further match occurs.
- COUNT=0xFFFFFFFE, COMPARE=5, PRESCALE=0, EN=1 -> COUNT goes 0xFFFFFFFF, 0, 1, …
  - The match lands 8 cycles after enable.
- Simultaneous events, each checked in the exact match cycle:
  - STATUS W1C -> PEND stays 1.
  - COUNT write of 0x10 -> COUNT reads 0x10 next cycle and PEND is set.
- Byte-lane write with `reg_we`=4'b0010 of 0xAABBCCDD to COMPARE=0 -> COMPARE reads 0x0000CC00.
- `rst` asserted mid-period -> all registers return to reset values on the next edge.
